// File: rtl/wash_phase_timer_if.sv
// wash_phase_timer_if: start/done handshake between the controller FSM and the phase timer.
// Latency: wires only; all timing is owned by the timer.
// Backpressure: none; the controller watches busy to decide when a new start will be accepted.
interface wash_phase_timer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] duration;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             paused;
  logic             done;
  logic [WIDTH-1:0] remaining;

  // Controller side: issues commands, observes phase status.
  modport master (
    output start, duration, pause, abort,
    input  busy, paused, done, remaining
  );

  // Timer side: consumes commands, reports phase status.
  modport slave (
    input  start, duration, pause, abort,
    output busy, paused, done, remaining
  );
endinterface

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: phase countdown responder with pause/abort for the washer controller FSM.
// Latency: start in cycle N gives done in cycle N+1+duration*PRESCALE; all outputs registered.
// Backpressure: none; start while busy is dropped, or reloads the phase when WASH_TIMER_RETRIGGER_EN is defined.
module wash_phase_timer #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  wash_phase_timer_if.slave bus
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

`ifdef WASH_TIMER_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] remaining;
  logic             busy;
  logic             paused;
  logic             done;
  logic             accept;
  logic             tick;

  // A start is taken from IDLE, or from a loaded phase when retriggering is built in.
  // tick marks the last prescaler cycle of the current countdown step.
  always_comb begin
    accept = bus.start && ((state == IDLE) || RETRIGGER);
    tick   = (presc == PRESC_LAST);
  end

  // Phase FSM: priority is rst > abort > start > pause > tick; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.abort) begin
        // Drop the phase silently; harmless when already idle.
        state     <= IDLE;
        presc     <= '0;
        remaining <= '0;
        busy      <= 1'b0;
        paused    <= 1'b0;
      end else if (accept) begin
        presc  <= '0;
        paused <= 1'b0;
        if (bus.duration == '0) begin
          // Zero-length phase completes on the next cycle without ever going busy.
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          state     <= RUN;
          remaining <= bus.duration;
          busy      <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (bus.pause) begin
          // Freeze prescaler and remaining; a tick landing here is simply not taken.
          state  <= PAUSED;
          paused <= 1'b1;
        end else begin
          // Counting runs whenever pause is low, including the cycle that leaves PAUSED,
          // so the frozen prescaler phase carries on exactly where it stopped.
          state  <= RUN;
          paused <= 1'b0;
          if (tick) begin
            presc <= '0;
            if (remaining == WIDTH'(1)) begin
              state     <= IDLE;
              remaining <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (remaining != '0) begin
              remaining <= remaining - WIDTH'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.paused    = paused;
  assign bus.done      = done;
  assign bus.remaining = remaining;

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: drives a PRESCALE=1 and a PRESCALE=4 timer with identical commands.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: none; the reference tracks active cycles per phase and derives remaining from them.
module tb_wash_phase_timer;

  localparam int W = 32;

`ifdef WASH_TIMER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] duration = '0;

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: phase loaded, phase length, active (unpaused) cycles so far.
  bit     m_on     [2] = '{1'b0, 1'b0};
  bit     m_paused [2] = '{1'b0, 1'b0};
  bit     m_done   [2] = '{1'b0, 1'b0};
  longint m_d      [2] = '{0, 0};
  longint m_act    [2] = '{0, 0};

  // Free-running clock.
  always #5 clk = ~clk;

  wash_phase_timer_if #(.WIDTH(W)) b1 ();
  wash_phase_timer_if #(.WIDTH(W)) b4 ();

  assign b1.start    = start;
  assign b1.duration = duration;
  assign b1.pause    = pause;
  assign b1.abort    = abort;
  assign b4.start    = start;
  assign b4.duration = duration;
  assign b4.pause    = pause;
  assign b4.abort    = abort;

  wash_phase_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  wash_phase_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  function automatic longint ps(int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Phase rules: a phase of D ticks ends after D*P unpaused cycles; remaining = D - active/P.
  task automatic model_update(int i);
    m_done[i] = 1'b0;
    if (rst || abort) begin
      m_on[i]     = 1'b0;
      m_paused[i] = 1'b0;
    end else if (start && (!m_on[i] || RETRIG)) begin
      m_paused[i] = 1'b0;
      m_act[i]    = 0;
      if (duration == '0) begin
        m_on[i]   = 1'b0;
        m_done[i] = 1'b1;
      end else begin
        m_on[i] = 1'b1;
        m_d[i]  = longint'(duration);
      end
    end else if (m_on[i]) begin
      if (pause) begin
        m_paused[i] = 1'b1;
      end else begin
        m_paused[i] = 1'b0;
        m_act[i]++;
        if (m_act[i] == m_d[i] * ps(i)) begin
          m_on[i]   = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_rem(int i);
    return m_on[i] ? 64'(m_d[i] - m_act[i] / ps(i)) : 64'd0;
  endfunction

  task automatic compare_all();
    check("p1_busy",      b1.busy,      m_on[0]);
    check("p1_paused",    b1.paused,    m_on[0] && m_paused[0]);
    check("p1_done",      b1.done,      m_done[0]);
    check("p1_remaining", b1.remaining, exp_rem(0));
    check("p4_busy",      b4.busy,      m_on[1]);
    check("p4_paused",    b4.paused,    m_on[1] && m_paused[1]);
    check("p4_done",      b4.done,      m_done[1]);
    check("p4_remaining", b4.remaining, exp_rem(1));
  endtask

  // One clock: edge samples the inputs, reference advances, outputs compared mid-cycle.
  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  initial begin
    int done_at;
    int n_done;

    // Reset state.
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    check("reset_busy", b1.busy, 1'b0);
    check("reset_remaining", b4.remaining, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step();

    // D=5, P=1: remaining 5..1 then done, then done drops.
    duration = 5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      check("d5_busy", b1.busy, 1'b1);
      check("d5_remaining", b1.remaining, k);
      step();
    end
    check("d5_done", b1.done, 1'b1);
    check("d5_busy_end", b1.busy, 1'b0);
    step();
    check("d5_done_drop", b1.done, 1'b0);
    for (int k = 0; k < 20; k++) step();

    // D=3, P=4: done exactly 13 cycles after the start cycle.
    duration = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (b4.done === 1'b1 && done_at == 0) done_at = c;
      step();
    end
    check("p4_done_cycle", done_at, 13);

    // D=10, P=1, pause during cycles 4-8.
    duration = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c >= 4 && c <= 9) check("pause_hold_rem", b1.remaining, 7);
      if (c >= 5 && c <= 9) check("pause_flag", b1.paused, 1'b1);
      if (b1.done === 1'b1 && done_at == 0) done_at = c;
      pause = (c >= 4 && c <= 8);
      step();
    end
    pause = 1'b0;
    check("pause_done_cycle", done_at, 16);
    settle();

    // D=8 aborted in cycle 4: idle next cycle, no done afterwards.
    duration = 8;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", b1.busy, 1'b0);
    check("abort_remaining", b1.remaining, 0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (b1.done === 1'b1 || b4.done === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Zero duration completes immediately without going busy.
    duration = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("d0_done", b1.done, 1'b1);
    check("d0_busy", b4.busy, 1'b0);
    step();
    check("d0_done_drop", b1.done, 1'b0);
    check("d0_busy_after", b1.busy, 1'b0);

    // Start D=6, second start D=2 in cycle 3.
    duration = 6;
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = 0;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) check("retrig_rem_c4", b1.remaining, RETRIG ? 2 : 3);
      if (b1.done === 1'b1) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      start = (c == 3);
      duration = (c == 3) ? 2 : 6;
      step();
    end
    start = 1'b0;
    check("retrig_done_cycle", done_at, RETRIG ? 6 : 7);
    check("retrig_done_count", n_done, 1);
    settle();

    // Reset mid-run clears everything; the next start behaves as after power-up.
    duration = 9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", b1.busy, 1'b0);
    check("rst_mid_remaining", b1.remaining, 0);
    check("rst_mid_done", b1.done, 1'b0);
    duration = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 6; c++) begin
      if (b1.done === 1'b1 && done_at == 0) done_at = c;
      step();
    end
    check("rst_restart_done", done_at, 3);

    // Full-scale duration loads and counts down.
    duration = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("full_scale_load", b1.remaining, 32'hFFFF_FFFF);
    step();
    step();
    step();
    check("full_scale_count", b1.remaining, 32'hFFFF_FFFC);
    settle();

    // Randomized commands against the reference.
    for (int n = 0; n < 2500; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      abort    = ($urandom_range(0, 29) == 0);
      start    = ($urandom_range(0, 7) == 0);
      duration = W'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Responder end of the FSM-to-timer start/done handshake used by the washing-machine controller.
- The controller FSM issues start with a duration. This block counts down, reports busy and remaining, and returns a one-cycle done pulse.
- Adds pause (door open / lid lock lost) and abort (cycle cancel) so the FSM can suspend or drop a phase without reloading.
- Instantiated beside the controller FSM in the washing-machine top level.

Parameters:
- WIDTH, 32: width of duration and remaining.
- PRESCALE, 1: clk cycles per countdown tick. Legal values ≥1. PRESCALE=1 means decrement every cycle.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to load duration and begin counting; sampled each cycle.
- duration  input  WIDTH  phase length in ticks; sampled only when start is accepted.
- pause  input  1  level; while high, countdown and prescaler hold.
- abort  input  1  pulse or level; cancels the phase with no done.
- busy  output  1  high while a phase is loaded (RUN or PAUSED).
- paused  output  1  high in PAUSED.
- done  output  1  single-cycle pulse at phase completion.
- remaining  output  WIDTH  ticks left; 0 when idle.

Behaviour:
- Reset: all outputs low or zero. State IDLE, prescaler 0. Reset mid-phase discards the phase and produces no done.
- All outputs are registered. done is high for exactly one cycle and never in consecutive cycles unless start is re-accepted.
- Input priority, every state: rst > abort > start (IDLE only) > pause > tick.
- States: IDLE, RUN, PAUSED.
- IDLE, start=1, duration=D>0, abort=0: next cycle RUN, busy=1, remaining=D, prescaler=0.
- IDLE, start=1, duration=0: next cycle done=1, busy=0, stay IDLE. This zero-length phase completes immediately.
- IDLE, start=1 and abort=1 in the same cycle: abort wins, nothing happens.
- RUN:
  - Prescaler counts 0..PRESCALE-1 while pause=0. A tick occurs on the cycle where prescaler==PRESCALE-1; prescaler then wraps to 0.
  - On a tick, remaining decrements by 1.
  - When remaining goes from 1 to 0: in that same next cycle done=1, busy=0, state IDLE.
  - Timing: start sampled in cycle N gives done in cycle N+1+D*PRESCALE.
- RUN, pause=1: next cycle PAUSED, paused=1. Prescaler and remaining frozen; a tick coincident with pause is suppressed.
- PAUSED, pause=0: next cycle RUN. Counting resumes from the frozen prescaler value, so no partial tick is lost or repeated.
- abort in RUN or PAUSED: next cycle IDLE, busy=0, paused=0, remaining=0, done=0.
- abort in IDLE: no effect.
- start while busy (macro undefined): ignored. duration is not sampled and the phase continues unaffected.
- Arithmetic: remaining never underflows; decrement only occurs when remaining>0. There is no wrap-around.
- Full-scale duration (all ones) is legal and counts fully.

Optional Feature:
- Macro: WASH_TIMER_RETRIGGER_EN.
- Defined: start=1 while busy (RUN or PAUSED), with no abort, reloads the phase.
  - Next cycle: remaining=duration, prescaler=0, state RUN (clears PAUSED even if pause is still high; pause re-enters PAUSED on the following cycle).
  - No done is issued for the preempted phase.
  - duration=0 on retrigger: done=1 next cycle, state IDLE.
- Undefined: start while busy is ignored, as described in Behaviour.

Test Plan:
- Reset, then start with D=5, PRESCALE=1, start sampled at cycle 10:
  - busy=1 from cycle 11.
  - remaining reads 5,4,3,2,1 over cycles 11-15.
  - Cycle 16: done=1, busy=0, remaining=0.
  - Cycle 17: done=0.
- PRESCALE=4, D=3, start at cycle 0: done exactly at cycle 13; remaining steps every 4 cycles.
- PRESCALE=1, D=10:
  - pause high cycles 4-8: remaining frozen at its cycle-4 value, paused=1 during cycles 5-9.
  - done arrives at cycle 11+5=16.
- D=8, abort at cycle 4:
  - Cycle 5: busy=0, remaining=0.
  - No done pulse within 20 further cycles.
- duration=0 start: done=1 next cycle, busy never asserts.
- start with D=6, then second start with D=2 at cycle 3:
  - Macro undefined: done at cycle 7.
  - WASH_TIMER_RETRIGGER_EN defined: remaining=2 at cycle 4, done at cycle 6, only one done pulse total.
- rst asserted mid-RUN: next cycle all outputs zero; start afterwards behaves as from power-up.
